// File: rtl/line_steer_fsm.sv
// Line-following steering controller: synchronises and debounces two line
// sensors, then drives a 2-bit motor command with turn dwell and lost-line timeout.
module line_steer_fsm #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TURN_MIN_CYCLES = 8,
    parameter int LOST_TIMEOUT    = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       sensL,
    input  logic       sensR,
    output logic [1:0] state,
    output logic       lost
);

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(TURN_MIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOST_LAST  = CNT_W'(LOST_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_LEFT,
        ST_RIGHT,
        ST_LOST
    } fsm_t;

    // Bit 1 carries the left sensor, bit 0 the right sensor.
    logic [1:0] raw;
    logic [1:0] filt;

    assign raw = {sensL, sensR};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sens
            logic             s1_reg;
            logic             s2_reg;
            logic             filt_reg;
            logic [CNT_W-1:0] db_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_reg   <= 1'b0;
                    s2_reg   <= 1'b0;
                    filt_reg <= 1'b0;
                    db_reg   <= '0;
                end else begin
                    s1_reg <= raw[gi];
                    s2_reg <= s1_reg;
                    if (s2_reg != filt_reg) begin
                        if (db_reg == DB_LAST) begin
                            filt_reg <= s2_reg;
                            db_reg   <= '0;
                        end else begin
                            db_reg <= db_reg + ONE;
                        end
                    end else begin
                        db_reg <= '0;
                    end
                end
            end

            assign filt[gi] = filt_reg;
        end
    endgenerate

    fsm_t             fsm_reg, fsm_next;
    logic [CNT_W-1:0] dwell_reg, dwell_next;
    logic [CNT_W-1:0] lost_cnt_reg, lost_cnt_next;
    logic [1:0]       state_reg, state_next;
    logic             lost_reg, lost_next;
    logic             in_motion;
    logic             both_low;
    logic             dwell_done;
    logic             lost_hit;

    always_comb begin
        in_motion  = (fsm_reg == ST_FWD) || (fsm_reg == ST_LEFT) || (fsm_reg == ST_RIGHT);
        both_low   = (filt == 2'b00);
        dwell_done = (dwell_reg >= DWELL_LAST);
        lost_hit   = in_motion && both_low && (lost_cnt_reg == LOST_LAST);
    end

    // Priority: disable beats lost timeout, which beats normal steering (and any dwell).
    always_comb begin
        fsm_next = fsm_reg;
        if (!en) begin
            fsm_next = ST_IDLE;
        end else if (lost_hit) begin
            fsm_next = ST_LOST;
        end else begin
            case (fsm_reg)
                ST_IDLE: fsm_next = ST_FWD;
                ST_FWD: begin
                    if (filt == 2'b10)      fsm_next = ST_LEFT;
                    else if (filt == 2'b01) fsm_next = ST_RIGHT;
                    else                    fsm_next = ST_FWD;
                end
                ST_LEFT, ST_RIGHT: begin
                    if (dwell_done) begin
                        if (filt == 2'b10)      fsm_next = ST_LEFT;
                        else if (filt == 2'b01) fsm_next = ST_RIGHT;
                        else                    fsm_next = ST_FWD;
                    end
                end
                ST_LOST: fsm_next = ST_LOST;
                default: fsm_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        dwell_next = dwell_reg;
        // Entering a turn, including a direct left/right swap, restarts the dwell.
        if ((fsm_next == ST_LEFT || fsm_next == ST_RIGHT) && (fsm_next != fsm_reg)) begin
            dwell_next = '0;
        end else if (dwell_reg != '1) begin
            dwell_next = dwell_reg + ONE;
        end

        lost_cnt_next = '0;
        if (en && in_motion && both_low && !lost_hit) begin
            lost_cnt_next = lost_cnt_reg + ONE;
        end

        state_next = 2'b00;
        case (fsm_next)
            ST_FWD:   state_next = 2'b11;
            ST_LEFT:  state_next = 2'b10;
            ST_RIGHT: state_next = 2'b01;
            default:  state_next = 2'b00;
        endcase
        lost_next = (fsm_next == ST_LOST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg      <= ST_IDLE;
            dwell_reg    <= '0;
            lost_cnt_reg <= '0;
            state_reg    <= 2'b00;
            lost_reg     <= 1'b0;
        end else begin
            fsm_reg      <= fsm_next;
            dwell_reg    <= dwell_next;
            lost_cnt_reg <= lost_cnt_next;
            state_reg    <= state_next;
            lost_reg     <= lost_next;
        end
    end

    assign state = state_reg;
    assign lost  = lost_reg;

endmodule

// File: tb/tb_line_steer_fsm.sv
// Directed bench for line_steer_fsm: each check compares {state, lost} one
// time unit after a rising edge against hand-derived edge-by-edge expectations.
module tb_line_steer_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       sensL;
    logic       sensR;
    logic [1:0] state;
    logic       lost;

    int tests = 0;
    int fails = 0;

    line_steer_fsm #(
        .DEBOUNCE_CYCLES(4),
        .TURN_MIN_CYCLES(8),
        .LOST_TIMEOUT   (16),
        .CNT_W          (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .sensL(sensL),
        .sensR(sensR),
        .state(state),
        .lost (lost)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [1:0] exp_state, input logic exp_lost);
        logic [2:0] obs;
        logic [2:0] exp;
        obs = {state, lost};
        exp = {exp_state, exp_lost};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $display("FAIL %s: observed state=%b lost=%b, expected state=%b lost=%b",
                     tag, obs[2:1], obs[0], exp[2:1], exp[0]);
            $error("%s check did not match", tag);
        end
    endtask

    // n edges, checking the outputs after every one
    task automatic hold(input string tag, input int n, input logic [1:0] exp_state, input logic exp_lost);
        for (int i = 0; i < n; i++) begin
            tick();
            chk(tag, exp_state, exp_lost);
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; sensL = 1'b0; sensR = 1'b0;

        // Reset holds IDLE even with en=1 and sensors toggling
        tick(); chk("rst_c1", 2'b00, 1'b0);
        sensL = 1'b1; sensR = 1'b0;
        tick(); chk("rst_c2", 2'b00, 1'b0);
        sensL = 1'b0; sensR = 1'b1;
        tick(); chk("rst_c3", 2'b00, 1'b0);
        sensL = 1'b0; sensR = 1'b0; rst = 1'b0;
        tick(); chk("rst_release_fwd", 2'b11, 1'b0);

        // Left turn latency: sensL sampled at edge k, LEFT at k+6.
        // sensR raised from k+3 so filt=11 by e+2 for the dwell check.
        sensL = 1'b1;
        hold("lat_k0_2", 3, 2'b11, 1'b0);
        sensR = 1'b1;
        hold("lat_k3_5", 3, 2'b11, 1'b0);
        tick(); chk("left_enter_k6", 2'b10, 1'b0);
        hold("dwell_left", 7, 2'b10, 1'b0);
        tick(); chk("dwell_exit_fwd", 2'b11, 1'b0);

        // Left again, then sensors swap to right-only mid-dwell
        sensR = 1'b0;
        hold("l2_pre", 4, 2'b11, 1'b0);
        sensL = 1'b0; sensR = 1'b1;
        hold("l2_pre_b", 2, 2'b11, 1'b0);
        tick(); chk("left2_enter", 2'b10, 1'b0);
        hold("dwell_lr_hold", 7, 2'b10, 1'b0);
        tick(); chk("right_at_dwell_end", 2'b01, 1'b0);

        // Right turn dwell then back to forward
        sensL = 1'b1;
        hold("dwell_right", 7, 2'b01, 1'b0);
        tick(); chk("right_exit_fwd", 2'b11, 1'b0);

        // 3-cycle glitch (low) on sensL is rejected
        sensL = 1'b0;
        tick(); tick(); tick();
        sensL = 1'b1;
        hold("glitch", 20, 2'b11, 1'b0);

        // Lost: raw 00 sampled at h+1, filt 00 at h+6, LOST at h+22
        sensL = 1'b0; sensR = 1'b0;
        hold("lost_wait", 21, 2'b11, 1'b0);
        tick(); chk("lost_enter", 2'b00, 1'b1);
        sensL = 1'b1; sensR = 1'b1;
        hold("lost_sticky", 10, 2'b00, 1'b1);
        en = 1'b0;
        tick(); chk("lost_en0_idle", 2'b00, 1'b0);
        en = 1'b1;
        tick(); chk("lost_restart_fwd", 2'b11, 1'b0);

        // Priority: en=0 while LEFT dwell count is 3
        sensR = 1'b0;
        hold("pri_fwd", 6, 2'b11, 1'b0);
        tick(); chk("pri_left_enter", 2'b10, 1'b0);
        hold("pri_dwell", 3, 2'b10, 1'b0);
        en = 1'b0;
        tick(); chk("pri_en0_mid_dwell", 2'b00, 1'b0);

        // Priority: rst on the edge that would otherwise time out
        sensL = 1'b0;
        hold("pri_idle", 8, 2'b00, 1'b0);
        en = 1'b1;
        tick(); chk("pri_fwd2", 2'b11, 1'b0);
        hold("pri_pre_lost", 15, 2'b11, 1'b0);
        rst = 1'b1;
        tick(); chk("pri_rst_vs_lost", 2'b00, 1'b0);
        rst = 1'b0;
        tick(); chk("post_rst_fwd", 2'b11, 1'b0);
        hold("post_rst_count_cleared", 3, 2'b11, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: observed no completion, expected finish before 100000");
        $fatal(1, "bench timeout");
    end

endmodule
